// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input port: per-bit synchroniser, optional debounce, edge capture with
// write-1-to-clear and a masked level interrupt.
module pio_in_edge_irq #(
  parameter int unsigned WIDTH           = 2,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter int unsigned EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int unsigned PrimeLen = SYNC_STAGES + 1;
  localparam int unsigned PrimeW   = $clog2(PrimeLen + 1);

  logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]  sync;
  logic [WIDTH-1:0]  deb_q;
  logic [WIDTH-1:0]  prev_q;
  logic [WIDTH-1:0]  edge_det;
  logic [WIDTH-1:0]  edge_set;
  logic [WIDTH-1:0]  irqmask_q, irqmask_d;
  logic [WIDTH-1:0]  edgecap_q, edgecap_d;
  logic [WIDTH-1:0]  edgecap_clr;
  logic [31:0]       readdata_d;
  logic [PrimeW-1:0] prime_q;
  logic              priming;
  logic              wr;
  logic              unused_wdata;

  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // After reset, deb/prev track sync directly until the chain holds real pin values.
  assign priming = (prime_q != PrimeW'(PrimeLen));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prime_q <= '0;
    end else if (priming) begin
      prime_q <= prime_q + 1'b1;
    end
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        deb_q <= '0;
      end else begin
        deb_q <= sync;
      end
    end
  end else begin : g_deb
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CntW-1:0] cnt_q [WIDTH];

    // Any return to the current debounced value restarts the stability window.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        deb_q <= '0;
        for (int b = 0; b < int'(WIDTH); b++) cnt_q[b] <= '0;
      end else begin
        for (int b = 0; b < int'(WIDTH); b++) begin
          if (priming) begin
            deb_q[b] <= sync[b];
            cnt_q[b] <= '0;
          end else if (sync[b] == deb_q[b]) begin
            cnt_q[b] <= '0;
          end else if (cnt_q[b] == CntW'(DEBOUNCE_CYCLES)) begin
            deb_q[b] <= sync[b];
            cnt_q[b] <= '0;
          end else begin
            cnt_q[b] <= cnt_q[b] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= '0;
    end else begin
      prev_q <= priming ? sync : deb_q;
    end
  end

  if (EDGE_TYPE == 0) begin : g_rise
    assign edge_det = deb_q & ~prev_q;
  end else if (EDGE_TYPE == 1) begin : g_fall
    assign edge_det = ~deb_q & prev_q;
  end else begin : g_any
    assign edge_det = deb_q ^ prev_q;
  end

  assign edge_set = priming ? '0 : edge_det;
  assign wr       = chipselect & ~write_n;

  always_comb begin
    irqmask_d   = irqmask_q;
    edgecap_clr = '0;
    if (wr && address == 2'd2) irqmask_d = writedata[WIDTH-1:0];
    if (wr && address == 2'd3) edgecap_clr = writedata[WIDTH-1:0];
    // A new edge wins over a simultaneous clear of the same bit.
    edgecap_d = (edgecap_q & ~edgecap_clr) | edge_set;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = deb_q;
      2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
      2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q <= '0;
      edgecap_q <= '0;
      readdata  <= '0;
    end else begin
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
      readdata  <= readdata_d;
    end
  end

  assign irq = |(edgecap_q & irqmask_q);

endmodule
